// File: rtl/mem_seq.sv
// mem_seq: load/store-multiple sequencer moving a masked set of eight registers
// to or from consecutive memory words, one access per cycle in ascending register order.
module mem_seq #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic              op_i,
    input  logic [DATA_W-1:0] base_addr_i,
    input  logic [7:0]        reg_mask_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [1:0]        mem_rw_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic [2:0]        rf_rd_addr_o,
    input  logic [DATA_W-1:0] rf_rd_data_i,
    output logic              rf_wr_en_o,
    output logic [2:0]        rf_wr_addr_o,
    output logic [DATA_W-1:0] rf_wr_data_o
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_e;

    localparam logic [1:0] RW_IDLE  = 2'b00;
    localparam logic [1:0] RW_WRITE = 2'b01;
    localparam logic [1:0] RW_READ  = 2'b10;

    state_e            state_q, state_d;
    logic              op_q, op_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [7:0]        mask_q, mask_d;
    logic [3:0]        cnt_q, cnt_d;

    // Last driven values of the data/address outputs, replayed outside ACCESS
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [2:0]        rf_rd_addr_q, rf_rd_addr_d;
    logic [2:0]        rf_wr_addr_q, rf_wr_addr_d;
    logic [DATA_W-1:0] rf_wr_data_q, rf_wr_data_d;

    logic [2:0]        cur_idx;
    logic [ADDR_W-1:0] cur_addr;
    logic              last_bit;

    if (DATA_W > ADDR_W) begin : g_base_hi
        logic unused_base_hi;
        assign unused_base_hi = ^base_addr_i[DATA_W-1:ADDR_W];
    end

    // Lowest set bit of the pending mask selects the register serviced this cycle
    always_comb begin
        cur_idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (mask_q[i]) begin
                cur_idx = 3'(i);
            end
        end
    end

    assign cur_addr = base_q + ADDR_W'(cnt_q);
    assign last_bit = ((mask_q & (mask_q - 8'd1)) == 8'd0);

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        base_d       = base_q;
        mask_d       = mask_q;
        cnt_d        = cnt_q;

        busy_o       = 1'b0;
        done_o       = 1'b0;
        mem_rw_o     = RW_IDLE;
        rf_wr_en_o   = 1'b0;
        mem_addr_o   = mem_addr_q;
        mem_wdata_o  = mem_wdata_q;
        rf_rd_addr_o = rf_rd_addr_q;
        rf_wr_addr_o = rf_wr_addr_q;
        rf_wr_data_o = rf_wr_data_q;

        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    op_d    = op_i;
                    base_d  = base_addr_i[ADDR_W-1:0];
                    mask_d  = reg_mask_i;
                    cnt_d   = 4'd0;
                    state_d = (reg_mask_i != 8'd0) ? ACCESS : DONE;
                end
            end
            ACCESS: begin
                busy_o     = 1'b1;
                mem_addr_o = cur_addr;
                mask_d     = mask_q & ~(8'd1 << cur_idx);
                cnt_d      = cnt_q + 4'd1;
                if (op_q) begin
                    mem_rw_o     = RW_WRITE;
                    rf_rd_addr_o = cur_idx;
                    mem_wdata_o  = rf_rd_data_i;
                end else begin
                    mem_rw_o     = RW_READ;
                    rf_wr_en_o   = 1'b1;
                    rf_wr_addr_o = cur_idx;
                    rf_wr_data_o = mem_rdata_i;
                end
                if (last_bit) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                busy_o  = 1'b1;
                done_o  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        mem_addr_d   = mem_addr_o;
        mem_wdata_d  = mem_wdata_o;
        rf_rd_addr_d = rf_rd_addr_o;
        rf_wr_addr_d = rf_wr_addr_o;
        rf_wr_data_d = rf_wr_data_o;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            op_q         <= 1'b0;
            base_q       <= '0;
            mask_q       <= 8'd0;
            cnt_q        <= 4'd0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            rf_rd_addr_q <= 3'd0;
            rf_wr_addr_q <= 3'd0;
            rf_wr_data_q <= '0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            base_q       <= base_d;
            mask_q       <= mask_d;
            cnt_q        <= cnt_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            rf_rd_addr_q <= rf_rd_addr_d;
            rf_wr_addr_q <= rf_wr_addr_d;
            rf_wr_data_q <= rf_wr_data_d;
        end
    end

endmodule

// File: tb/tb_mem_seq.sv
// tb_mem_seq: drives mem_seq with directed and random load/store-multiple requests
// against a word memory and register file, predicting results from the transfer rules.
module tb_mem_seq;

    localparam int ADDR_W = 6;
    localparam int DATA_W = 16;
    localparam int DEPTH  = 64;

    logic              clk = 1'b0;
    logic              rstN;
    logic              start;
    logic              op;
    logic [DATA_W-1:0] baseAddr;
    logic [7:0]        regMask;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] memAddr;
    logic [1:0]        memRw;
    logic [DATA_W-1:0] memWdata;
    logic [DATA_W-1:0] memRdata;
    logic [2:0]        rfRdAddr;
    logic [DATA_W-1:0] rfRdData;
    logic              rfWrEn;
    logic [2:0]        rfWrAddr;
    logic [DATA_W-1:0] rfWrData;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rf  [8];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign memRdata = mem[memAddr];
    assign rfRdData = rf[rfRdAddr];

    mem_seq #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk_i       (clk),
        .rst_ni      (rstN),
        .start_i     (start),
        .op_i        (op),
        .base_addr_i (baseAddr),
        .reg_mask_i  (regMask),
        .busy_o      (busy),
        .done_o      (done),
        .mem_addr_o  (memAddr),
        .mem_rw_o    (memRw),
        .mem_wdata_o (memWdata),
        .mem_rdata_i (memRdata),
        .rf_rd_addr_o(rfRdAddr),
        .rf_rd_data_i(rfRdData),
        .rf_wr_en_o  (rfWrEn),
        .rf_wr_addr_o(rfWrAddr),
        .rf_wr_data_o(rfWrData)
    );

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle, committing any memory/register write the DUT requests at the edge
    task automatic tick();
        logic [1:0]        rw;
        logic [ADDR_W-1:0] wa;
        logic [DATA_W-1:0] wd;
        logic              we;
        logic [2:0]        ra;
        logic [DATA_W-1:0] rd;
        #1;
        rw = memRw; wa = memAddr; wd = memWdata;
        we = rfWrEn; ra = rfWrAddr; rd = rfWrData;
        checkOutput("rw_legal", 64'(rw != 2'b11), 64'd1);
        @(posedge clk);
        if (rw == 2'b01) mem[wa] <= wd;
        if (we) rf[ra] <= rd;
        #1;
    endtask

    task automatic junkInputs();
        start    = 1'($urandom);
        op       = 1'($urandom);
        baseAddr = DATA_W'($urandom);
        regMask  = 8'($urandom);
    endtask

    // One full request from IDLE, checked cycle by cycle against the transfer rules
    task automatic applyStimulus(input logic opIn, input logic [DATA_W-1:0] baseIn, input logic [7:0] maskIn);
        logic [DATA_W-1:0] memBefore [DEPTH];
        logic [DATA_W-1:0] rfBefore  [8];
        logic [DATA_W-1:0] memExp    [DEPTH];
        logic [DATA_W-1:0] rfExp     [8];
        int idxList[$];
        int addrList[$];
        int n;
        int bad;
        memBefore = mem; rfBefore = rf; memExp = mem; rfExp = rf;
        n = 0;
        for (int i = 0; i < 8; i++) begin
            if (maskIn[i]) begin
                addrList.push_back((int'(baseIn[ADDR_W-1:0]) + n) % DEPTH);
                idxList.push_back(i);
                if (opIn) memExp[addrList[n]] = rfBefore[i];
                else      rfExp[i] = memBefore[addrList[n]];
                n++;
            end
        end
        start = 1'b1; op = opIn; baseAddr = baseIn; regMask = maskIn;
        tick();
        for (int k = 0; k < n; k++) begin
            checkOutput("acc_busy", 64'(busy), 64'd1);
            checkOutput("acc_done", 64'(done), 64'd0);
            checkOutput("acc_addr", 64'(memAddr), 64'(addrList[k]));
            checkOutput("acc_rw", 64'(memRw), opIn ? 64'd1 : 64'd2);
            checkOutput("acc_rfwe", 64'(rfWrEn), 64'(!opIn));
            if (opIn) begin
                checkOutput("st_rdaddr", 64'(rfRdAddr), 64'(idxList[k]));
                checkOutput("st_wdata", 64'(memWdata), 64'(rfBefore[idxList[k]]));
            end else begin
                checkOutput("ld_wraddr", 64'(rfWrAddr), 64'(idxList[k]));
                checkOutput("ld_wrdata", 64'(rfWrData), 64'(memBefore[addrList[k]]));
            end
            junkInputs();
            tick();
        end
        checkOutput("done_pulse", 64'(done), 64'd1);
        checkOutput("done_busy", 64'(busy), 64'd1);
        checkOutput("done_rw", 64'(memRw), 64'd0);
        checkOutput("done_rfwe", 64'(rfWrEn), 64'd0);
        junkInputs();
        tick();
        start = 1'b0;
        checkOutput("idle_done", 64'(done), 64'd0);
        checkOutput("idle_busy", 64'(busy), 64'd0);
        checkOutput("idle_rw", 64'(memRw), 64'd0);
        bad = 0;
        for (int a = 0; a < DEPTH; a++) if (mem[a] !== memExp[a]) bad++;
        for (int r = 0; r < 8; r++) if (rf[r] !== rfExp[r]) bad++;
        checkOutput("final_state", 64'(bad), 64'd0);
    endtask

    initial begin
        logic [DATA_W-1:0] old48;
        logic [DATA_W-1:0] oldR2;
        int doneCount;
        for (int a = 0; a < DEPTH; a++) mem[a] <= DATA_W'($urandom);
        for (int r = 0; r < 8; r++) rf[r] <= DATA_W'($urandom);
        rstN = 1'b0; start = 1'b0; op = 1'b0; baseAddr = '0; regMask = 8'd0;
        tick();
        tick();
        $display("[TB] checking reset state");
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_done", 64'(done), 64'd0);
        checkOutput("rst_rw", 64'(memRw), 64'd0);
        checkOutput("rst_rfwe", 64'(rfWrEn), 64'd0);
        checkOutput("rst_addr", 64'(memAddr), 64'd0);
        checkOutput("rst_wdata", 64'(memWdata), 64'd0);
        checkOutput("rst_rdaddr", 64'(rfRdAddr), 64'd0);
        checkOutput("rst_wraddr", 64'(rfWrAddr), 64'd0);
        checkOutput("rst_wrdata", 64'(rfWrData), 64'd0);
        rstN = 1'b1;
        tick();

        $display("[TB] directed load base 20");
        mem[20] <= 16'h0001; mem[21] <= 16'h000F;
        #1;
        applyStimulus(1'b0, 16'd20, 8'b0000_0011);
        checkOutput("ld_r0", 64'(rf[0]), 64'h0001);
        checkOutput("ld_r1", 64'(rf[1]), 64'h000F);

        $display("[TB] directed store base 46");
        rf[2] <= 16'h1234; rf[4] <= 16'hABCD;
        #1;
        old48 = mem[48];
        applyStimulus(1'b1, 16'd46, 8'b0001_0100);
        checkOutput("st_m46", 64'(mem[46]), 64'h1234);
        checkOutput("st_m47", 64'(mem[47]), 64'hABCD);
        checkOutput("st_m48", 64'(mem[48]), 64'(old48));

        $display("[TB] directed wrap store base 62");
        applyStimulus(1'b1, 16'd62, 8'hFF);
        for (int k = 0; k < 8; k++) checkOutput("wrap_mem", 64'(mem[(62 + k) % DEPTH]), 64'(rf[k]));

        $display("[TB] directed empty mask");
        applyStimulus(1'b0, 16'd7, 8'h00);
        applyStimulus(1'b1, 16'hFFC5, 8'h00);

        $display("[TB] reset during load");
        mem[10] <= 16'h5A5A; mem[11] <= 16'h6B6B; mem[12] <= 16'h1111;
        rf[0] <= 16'h0000; rf[2] <= 16'hBEEF;
        #1;
        oldR2 = 16'hBEEF;
        start = 1'b1; op = 1'b0; baseAddr = 16'd10; regMask = 8'h07;
        tick();
        start = 1'b0;
        checkOutput("abort_t1_addr", 64'(memAddr), 64'd10);
        checkOutput("abort_t1_rw", 64'(memRw), 64'd2);
        tick();
        rstN = 1'b0;
        tick();
        checkOutput("abort_rw", 64'(memRw), 64'd0);
        checkOutput("abort_busy", 64'(busy), 64'd0);
        checkOutput("abort_done", 64'(done), 64'd0);
        checkOutput("abort_rfwe", 64'(rfWrEn), 64'd0);
        checkOutput("abort_addr", 64'(memAddr), 64'd0);
        rstN = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            checkOutput("abort_nodone", 64'(done), 64'd0);
            checkOutput("abort_norw", 64'(memRw), 64'd0);
        end
        checkOutput("abort_r0", 64'(rf[0]), 64'h5A5A);
        checkOutput("abort_r2", 64'(rf[2]), 64'(oldR2));

        $display("[TB] start held high, single-bit mask");
        start = 1'b1; op = 1'($urandom); baseAddr = DATA_W'($urandom); regMask = 8'h01;
        doneCount = 0;
        for (int j = 1; j <= 12; j++) begin
            tick();
            if (done === 1'b1) doneCount++;
            checkOutput("held_done", 64'(done), 64'((j % 3) == 2));
            checkOutput("held_access", 64'(memRw != 2'b00), 64'((j % 3) == 1));
            checkOutput("held_busy", 64'(busy), 64'((j % 3) != 0));
        end
        start = 1'b0;
        checkOutput("held_done_count", 64'(doneCount), 64'd4);
        tick();
        checkOutput("held_idle", 64'(busy), 64'd0);

        $display("[TB] random requests");
        for (int t = 0; t < 40; t++) begin
            applyStimulus(1'($urandom), DATA_W'($urandom),
                          ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
